// File: rtl/tt_um_logic_op_scheduler.sv
// tt_um_logic_op_scheduler: command-driven sequencer for an 8-bit AND/OR/XOR/NAND unit
module tt_um_logic_op_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [7:0]        uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] a, b, res, r;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op;
  logic chain, ready, busy, done, acc, abort, run;
  logic unused;
  assign unused = &{1'b0, uio_in[7:3]};
  assign acc = ena && uio_in[0] && (ready || uio_in[2:1] == 2'b11);
  assign abort = acc && uio_in[2:1] == 2'b11;
  assign run = acc && uio_in[2:1] == 2'b10;
  assign r = op == 2'd0 ? a & b : op == 2'd1 ? a | b : op == 2'd2 ? a ^ b : ~(a & b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = !ena ? state : abort ? IDLE :
              state == IDLE ? (run ? EXEC : IDLE) :
              state == EXEC ? (cnt == '0 ? DONE : EXEC) : IDLE;
  end
  always_comb begin
    ready = state == IDLE;
    busy = state == EXEC;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      res <= '0;
      cnt <= '0;
      op <= '0;
      chain <= 1'b0;
    end else if (ena) begin
      if (abort) begin
        a <= '0;
        b <= '0;
        res <= '0;
        cnt <= '0;
      end else if (acc && uio_in[2:1] == 2'b00) a <= ui_in;
      else if (acc && uio_in[2:1] == 2'b01) b <= ui_in;
      else if (run) begin
        op <= ui_in[1:0];
        cnt <= ui_in[CNT_W+1:2];
        chain <= ui_in[7];
      end else if (busy) begin
        res <= r;
        if (chain) a <= r;
        b <= {b[DATA_W-2:0], b[DATA_W-1]};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  assign uo_out = res;
  assign uio_out = {res == '0, done, busy, ready, 4'b0000};
  assign uio_oe = 8'hF0;
endmodule

// File: tb/tb_tt_um_logic_op_scheduler.sv
// tb_tt_um_logic_op_scheduler: directed and randomized checks against a job-level model
module tb_tt_um_logic_op_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0;

  tt_um_logic_op_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] t, input logic [7:0] d);
    ui_in = d;
    uio_in = {5'b0, t, 1'b1};
    step();
    uio_in = 8'h00;
  endtask

  function automatic logic [7:0] f(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'd0: return x & y;
      2'd1: return x | y;
      2'd2: return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Whole job as N+1 plain iterations; returns final A, B and result
  task automatic job(input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op,
                     input int n, input bit ch,
                     output logic [7:0] fa, output logic [7:0] fb, output logic [7:0] fr);
    fa = a0;
    fb = b0;
    fr = 8'h00;
    for (int i = 0; i <= n; i++) begin
      fr = f(op, fa, fb);
      if (ch) fa = fr;
      fb = {fb[6:0], fb[7]};
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [7:0] exp_res, input bit junk);
    int c = 0;
    while (!uio_out[6] && c < 100) begin
      if (junk) begin
        ui_in = 8'($urandom);
        uio_in = {6'b0, 1'($urandom), 1'b1};
      end
      step();
      c++;
    end
    uio_in = 8'h00;
    chk({tag, "_cycles"}, c, exp_cyc);
    chk({tag, "_result"}, uo_out, exp_res);
    chk({tag, "_zero"}, uio_out[7], exp_res == 8'h00);
    chk({tag, "_done"}, uio_out[6:4], 3'b100);
    step();
    chk({tag, "_ready"}, uio_out[6:4], 3'b001);
  endtask

  initial begin
    logic [7:0] ma, mb, mr, a0, b0;
    logic [1:0] op;
    int n;
    bit ch;
    repeat (2) step();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h90);
    chk("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    step();
    cmd(2'b00, 8'h5A);
    cmd(2'b01, 8'hFF);
    cmd(2'b10, 8'h09);
    chk("ena0_uo", uo_out, 8'h00);
    chk("ena0_uio", uio_out, 8'h90);
    ena = 1'b1;
    cmd(2'b10, 8'h01);
    wait_done("ena0_ab", 1, 8'h00, 1'b0);

    cmd(2'b00, 8'hA5);
    cmd(2'b01, 8'h0F);
    chk("load_ready", uio_out, 8'h90);
    cmd(2'b10, 8'h00);
    chk("and_busy", uio_out[6:4], 3'b010);
    wait_done("and", 1, 8'h05, 1'b0);

    cmd(2'b00, 8'h80);
    cmd(2'b01, 8'h01);
    cmd(2'b10, 8'h01);
    wait_done("or", 1, 8'h81, 1'b0);

    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h01);
    cmd(2'b10, 8'h8E);
    step(); chk("xor_e1", uo_out, 8'h01);
    step(); chk("xor_e2", uo_out, 8'h03);
    step(); chk("xor_e3", uo_out, 8'h07);
    chk("xor_e3_busy", uio_out[6:4], 3'b010);
    wait_done("xor", 1, 8'h0F, 1'b0);
    cmd(2'b00, 8'h00);
    cmd(2'b10, 8'h01);
    wait_done("xor_b", 1, 8'h10, 1'b0);

    cmd(2'b00, 8'h3C);
    cmd(2'b01, 8'hFF);
    cmd(2'b10, 8'h7C);
    cmd(2'b00, 8'hFF);
    step();
    chk("busy_drop", uo_out, 8'h3C);
    step();
    step();
    cmd(2'b11, 8'h00);
    chk("abort_uo", uo_out, 8'h00);
    chk("abort_uio", uio_out, 8'h90);
    step();
    chk("abort_hold", uio_out, 8'h90);
    cmd(2'b00, 8'hF0);
    cmd(2'b10, 8'h01);
    wait_done("abort_b", 1, 8'hF0, 1'b0);

    a0 = 8'h96; b0 = 8'h3B;
    job(a0, b0, 2'd3, 2, 1'b1, ma, mb, mr);
    cmd(2'b00, a0);
    cmd(2'b01, b0);
    cmd(2'b10, 8'h8B);
    step();
    ena = 1'b0;
    uio_in = 8'h07;
    repeat (3) step();
    chk("freeze_busy", uio_out[6:4], 3'b010);
    uio_in = 8'h00;
    ena = 1'b1;
    wait_done("freeze", 2, mr, 1'b0);

    cmd(2'b10, 8'h28);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h90);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_hold", uio_out, 8'h90);

    for (int k = 0; k < 24; k++) begin
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      op = 2'($urandom);
      n = (k == 0) ? 31 : int'($urandom_range(0, 7));
      ch = 1'($urandom);
      job(a0, b0, op, n, ch, ma, mb, mr);
      cmd(2'b00, a0);
      cmd(2'b01, b0);
      cmd(2'b10, {ch, 5'(n), op});
      wait_done($sformatf("rnd%0d", k), n + 1, mr, 1'b1);
      if (k % 4 == 0) begin
        cmd(2'b10, 8'h01);
        wait_done($sformatf("rnd%0d_st", k), 1, ma | mb, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
